// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: synchronises SCL/SDA, matches a 7-bit address,
// ACKs write transfers and presents each received byte as a one-cycle strobe.
module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    state_t     state, state_d;
    logic       scl_meta, scl_s, scl_prev;
    logic       sda_meta, sda_s, sda_prev;
    logic [2:0] cnt, cnt_d;
    logic       full, full_d;
    logic [7:0] shift, shift_d;
    logic       first_flag, first_flag_d;
    logic       sda_oe_d, busy_d, rx_valid_d, rx_first_d;
    logic [7:0] rx_data_d;
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Synchronisers preset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_meta, scl_s, scl_prev} <= 3'b111;
            {sda_meta, sda_s, sda_prev} <= 3'b111;
        end else begin
            {scl_meta, scl_s, scl_prev} <= {scl_in, scl_meta, scl_s};
            {sda_meta, sda_s, sda_prev} <= {sda_in, sda_meta, sda_s};
        end
    end

    assign scl_rise  = !scl_prev && scl_s;
    assign scl_fall  = scl_prev && !scl_s;
    assign start_det = scl_prev && scl_s && sda_prev && !sda_s;
    assign stop_det  = scl_prev && scl_s && !sda_prev && sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            full       <= 1'b0;
            shift      <= 8'h00;
            first_flag <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            full       <= full_d;
            shift      <= shift_d;
            first_flag <= first_flag_d;
            sda_oe     <= sda_oe_d;
            busy       <= busy_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            rx_first   <= rx_first_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        full_d       = full;
        shift_d      = shift;
        first_flag_d = first_flag;
        sda_oe_d     = sda_oe;
        busy_d       = busy;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        rx_first_d   = rx_first;

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift[6:0], sda_s};
                        cnt_d   = cnt + 3'd1;
                        if (cnt == 3'd7) full_d = 1'b1;
                    end else if (scl_fall && full) begin
                        full_d = 1'b0;
                        if (state == S_DATA) begin
                            rx_data_d    = shift;
                            rx_valid_d   = 1'b1;
                            rx_first_d   = first_flag;
                            first_flag_d = 1'b0;
                            sda_oe_d     = 1'b1;
                            state_d      = S_DATA_ACK;
                        end else if (shift[7:1] == ADDR && !shift[0]) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d     = 1'b0;
                        cnt_d        = 3'd0;
                        first_flag_d = 1'b1;
                        state_d      = S_DATA;
                    end
                end
                S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = S_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Write-only I2C target (slave) receiver that sits directly upstream of the 7-segment driver stage. It synchronises the SCL/SDA pins and detects START/STOP. It matches a 7-bit address, acknowledges write transfers, and hands each received data byte downstream as a one-cycle valid strobe. The segment logic latches these bytes into display registers.

## Interface
- `ADDR`, default `7'h2A`: 7-bit target address.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `scl_in` in 1: raw SCL pin input (asynchronous).
- `sda_in` in 1: raw SDA pin input (asynchronous).
- `sda_oe` out 1: 1 means pull SDA low. Output data is tied to 0 externally (open drain).
- `rx_data` out 8: last received data byte, MSB first on the wire.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `rx_first` out 1: qualifies `rx_valid`. It is 1 for the first data byte after the address.
- `busy` out 1: 1 from address match until STOP, repeated START, or reset.

## Operation
- **Synchronisers.** SCL and SDA each pass through a 2-FF synchroniser. A further register holds the previous synchronised value for edge detection.
  - `scl_rise`: previous 0, current 1. `scl_fall`: previous 1, current 0.
  - START: synchronised SDA falls while SCL is high in both the previous and current samples.
  - STOP: synchronised SDA rises while SCL is high in both the previous and current samples.
  - If SCL and SDA change in the same cycle, this is not a START or STOP.
- **States:** IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- **IDLE.** Waits for START, then goes to ADDR with the 3-bit bit counter at 0.
- **ADDR.** On each `scl_rise`, shifts SDA into an 8-bit shift register and increments the counter. After the 8th bit is sampled, the next `scl_fall` decides:
  - Address bits [7:1] == `ADDR` and R/W bit == 0: set `sda_oe`=1, `busy`=1, and go to ADDR_ACK.
  - Any other case, including reads: leave `sda_oe`=0 (NACK) and go to IGNORE.
- **ADDR_ACK.** On the next `scl_fall`, sets `sda_oe`=0, clears the counter, sets the internal first-byte flag, and goes to DATA.
- **DATA.** Shifts on `scl_rise` as in ADDR. On the `scl_fall` after the 8th bit:
  - `rx_data` loads the shift register.
  - `rx_valid` pulses for one cycle.
  - `rx_first` equals the first-byte flag, which then clears.
  - `sda_oe`=1 (ACK), and the state goes to DATA_ACK.
- **DATA_ACK.** On the next `scl_fall`, sets `sda_oe`=0, clears the counter, and returns to DATA. There is no limit on the byte count.
- **IGNORE.** Ignores everything except START and STOP.
- **START in any state** (repeated START): `sda_oe`=0, `busy`=0, counter=0, go to ADDR. A partial byte is discarded with no `rx_valid`.
- **STOP in any state:** `sda_oe`=0, `busy`=0, go to IDLE. A partial byte is discarded.
- **Reset values:** state=IDLE, `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_first`=0, `busy`=0, counter=0, synchronisers=1 (bus idle). A reset mid-transfer drops the transaction. The block responds again only after a new START.
- The block never stretches the clock and never drives SDA except during ACK slots.

## Timing
- **Latency from pin to detect:** 3 `clk` cycles, i.e. 2 synchroniser stages plus 1 edge register.
- **ACK timing:** `sda_oe` changes in the cycle after the internal `scl_fall` detect, about 4 `clk` cycles after the SCL pin falls.
- **Data hand-off:** `rx_valid`, `rx_data` and `rx_first` update in the same cycle that `sda_oe` rises for the data ACK. `rx_data` holds until the next valid byte.
- **Clock ratio:** `clk` must be at least 16× the SCL frequency. This guarantees SDA hold after SCL falls exceeds the synchroniser delay, e.g. 100 kHz SCL with a 10 MHz `clk`.
- **Back-to-back bytes:** `rx_valid` pulses are separated by at least 9 SCL periods. No buffering is required downstream.

## Test plan
- **Single write.** Drive START, 0x54 (addr 0x2A, W), 0x3F, STOP at 100 kHz SCL with a 10 MHz `clk`.
  - ACK is asserted in both ACK slots.
  - One `rx_valid` pulse with `rx_data`=0x3F and `rx_first`=1.
  - `busy` is high from the address ACK until STOP.
- **Multi-byte write.** Drive START, 0x54, 0x01, 0x06, 0x5B, STOP.
  - Three `rx_valid` pulses with data 0x01, 0x06, 0x5B.
  - `rx_first`=1 only on the 0x01 pulse.
- **Address mismatch and read.** Drive START, 0x56, 0xFF, STOP; then START, 0x55, STOP.
  - `sda_oe` stays 0 throughout.
  - No `rx_valid` and `busy`=0.
- **Repeated START mid-byte.** Drive START, 0x54, then 4 bits of a byte, then repeated START, 0x54, 0xA5, STOP.
  - Exactly one `rx_valid`, with data 0xA5 and `rx_first`=1.
- **Reset mid-operation.** Assert `rst` during the ADDR_ACK slot.
  - `sda_oe` drops to 0 immediately (asynchronously).
  - All outputs return to their reset values.
  - Subsequent data bits with no new START produce no ACK. A following full START, 0x54, 0x77, STOP transaction delivers 0x77.
